corn_input_sequencer: RTL and testbench



---
 rtl/corn_input_sequencer.sv | 170 +++++++++++++++++
 tb/tb_corn_input_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/corn_input_sequencer.sv
// Ping-pong frame buffer in front of the CORN core: fills 16-word frames from a
// valid/ready host stream and replays each full frame through the core load protocol.
module corn_input_sequencer #(
  parameter int WIDTH     = 16,
  parameter int NUM_WORDS = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             InValid,
  input  logic [WIDTH-1:0] InData,
  output logic             InReady,
  input  logic             Done,
  output logic             InputReady,
  output logic [WIDTH-1:0] Inputs,
  output logic             Busy,
  output logic [7:0]       FrameCount
);

  localparam int CW = $clog2(NUM_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE     = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [WIDTH-1:0] bank_r [2][NUM_WORDS];
  logic [1:0]       full_r;
  logic [1:0]       full_nxt_s;
  logic             fill_bank_r;
  logic [CW-1:0]    fill_cnt_r;
  logic             stream_bank_r;
  logic [CW-1:0]    k_r;
  state_t           state_r;
  logic             seen_hi_r;
  logic             input_ready_r;
  logic [WIDTH-1:0] inputs_r;
  logic             busy_r;
  logic [7:0]       frame_count_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             fill_set_s;
  logic             stream_clr_s;

  // Ready depends only on registered state and the shared enable, never on InValid.
  assign in_ready_s   = En & ~Rst & ~full_r[fill_bank_r];
  assign accept_s     = InValid & in_ready_s;
  assign fill_set_s   = accept_s & (fill_cnt_r == LAST_IDX);
  assign stream_clr_s = (state_r == STREAM) & En & (k_r == LAST_IDX);

  assign InReady    = in_ready_s;
  assign InputReady = input_ready_r;
  assign Inputs     = inputs_r;
  assign Busy       = busy_r;
  assign FrameCount = frame_count_r;

  // Next value of the per-bank full flags; fill only sets a clear flag, stream only clears a set one.
  always_comb begin
    full_nxt_s = full_r;
    for (int b = 0; b < 2; b++) begin
      if (fill_set_s && (fill_bank_r == 1'(b))) begin
        full_nxt_s[b] = 1'b1;
      end else if (stream_clr_s && (stream_bank_r == 1'(b))) begin
        full_nxt_s[b] = 1'b0;
      end else begin
        full_nxt_s[b] = full_r[b];
      end
    end
  end

  // Full flag register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      full_r <= 2'b00;
    end else begin
      full_r <= full_nxt_s;
    end
  end

  // Fill side: buffer writes and fill pointers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      fill_bank_r <= 1'b0;
      fill_cnt_r  <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < NUM_WORDS; w++) begin
          bank_r[b][w] <= '0;
        end
      end
    end else if (accept_s) begin
      bank_r[fill_bank_r][fill_cnt_r] <= InData;
      if (fill_cnt_r == LAST_IDX) begin
        fill_cnt_r  <= '0;
        fill_bank_r <= ~fill_bank_r;
      end else begin
        fill_cnt_r <= fill_cnt_r + CW'(1);
      end
    end
  end

  // Stream FSM with registered core-side outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r       <= IDLE;
      stream_bank_r <= 1'b0;
      k_r           <= '0;
      seen_hi_r     <= 1'b0;
      input_ready_r <= 1'b0;
      inputs_r      <= '0;
      busy_r        <= 1'b0;
      frame_count_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (En && full_r[stream_bank_r]) begin
            state_r       <= PULSE;
            input_ready_r <= 1'b1;
            inputs_r      <= '0;
            busy_r        <= 1'b1;
          end
        end
        PULSE: begin
          // An issued pulse always completes, even if En dropped meanwhile.
          state_r       <= STREAM;
          input_ready_r <= 1'b0;
          k_r           <= '0;
          inputs_r      <= bank_r[stream_bank_r][CW'(0)];
        end
        STREAM: begin
          if (En) begin
            if (k_r == LAST_IDX) begin
              state_r       <= WAIT_DONE;
              inputs_r      <= '0;
              k_r           <= '0;
              stream_bank_r <= ~stream_bank_r;
            end else begin
              k_r      <= k_r + CW'(1);
              inputs_r <= bank_r[stream_bank_r][k_r + CW'(1)];
            end
          end
        end
        WAIT_DONE: begin
          // Done is tracked regardless of En; the remembered fall is acted on once enabled.
          if (seen_hi_r && !Done) begin
            if (En) begin
              seen_hi_r     <= 1'b0;
              frame_count_r <= frame_count_r + 8'd1;
              state_r       <= IDLE;
              busy_r        <= 1'b0;
            end
          end else if (Done) begin
            seen_hi_r <= 1'b1;
          end
        end
        default: begin
          state_r       <= IDLE;
          input_ready_r <= 1'b0;
          inputs_r      <= '0;
          busy_r        <= 1'b0;
          seen_hi_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corn_input_sequencer.sv
// Directed self-checking bench for corn_input_sequencer.
module tb_corn_input_sequencer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        En;
  logic        InValid;
  logic [15:0] InData;
  logic        InReady;
  logic        Done;
  logic        InputReady;
  logic [15:0] Inputs;
  logic        Busy;
  logic [7:0]  FrameCount;

  int tests_run = 0;
  int fail_cnt  = 0;
  logic [15:0] frame [16];

  corn_input_sequencer #(.WIDTH(16), .NUM_WORDS(16)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .InValid(InValid), .InData(InData),
    .InReady(InReady), .Done(Done), .InputReady(InputReady), .Inputs(Inputs),
    .Busy(Busy), .FrameCount(FrameCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Rst = 1'b1; InValid = 1'b0; Done = 1'b0;
    tick; tick;
    Rst = 1'b0;
    #1;
  endtask

  // Offers the 16 frame words back to back; the last is accepted at the final edge (E).
  task automatic send_frame;
    for (int i = 0; i < 16; i++) begin
      InValid = 1'b1;
      InData  = frame[i];
      chk("fill_inready", 32'(InReady), 32'd1);
      tick;
    end
    InValid = 1'b0;
  endtask

  // From edge E: pulse at E+1, words at E+2..E+17, zero at E+18.
  task automatic stream_check;
    tick;
    chk("pulse", 32'(InputReady), 32'd1);
    chk("pulse_inputs", 32'(Inputs), 32'd0);
    chk("busy", 32'(Busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      tick;
      chk("pulse_low", 32'(InputReady), 32'd0);
      chk("word", 32'(Inputs), 32'(frame[i]));
    end
    tick;
    chk("tail_zero", 32'(Inputs), 32'd0);
  endtask

  initial begin
    int accepted;
    int pulses;
    int first_low;
    frame = '{16'h00A8, 16'h00D7, 16'h0091, 16'h003C, 16'h0012, 16'h00E5, 16'h007F, 16'h0044,
              16'h00B0, 16'h0009, 16'h006A, 16'h00C3, 16'h002D, 16'h00F1, 16'h0088, 16'h005E};
    Rst = 1'b1; En = 1'b1; InValid = 1'b0; InData = 16'h0000; Done = 1'b0;
    tick; tick;
    chk("rst_inready", 32'(InReady), 32'd0);
    chk("rst_inputready", 32'(InputReady), 32'd0);
    chk("rst_inputs", 32'(Inputs), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_framecount", 32'(FrameCount), 32'd0);
    Rst = 1'b0;
    #1;

    // Basic frame load and replay.
    send_frame;
    stream_check;

    // Done handshake: low for a while, high 3 cycles, then falls.
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("wait_fc", 32'(FrameCount), 32'd0);
      chk("wait_busy", 32'(Busy), 32'd1);
    end
    Done = 1'b1;
    tick; tick; tick;
    chk("done_hi_fc", 32'(FrameCount), 32'd0);
    Done = 1'b0;
    tick;
    chk("done_fall_fc", 32'(FrameCount), 32'd1);
    chk("done_fall_busy", 32'(Busy), 32'd0);

    // Continuous 48-word host stream with Done stuck low.
    do_reset;
    accepted = 0; pulses = 0; first_low = -1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      InValid = (accepted < 48);
      InData  = 16'(accepted);
      if (!InReady && first_low < 0) first_low = accepted;
      if (InValid && InReady) accepted++;
      tick;
      if (InputReady) pulses++;
    end
    InValid = 1'b0;
    chk("first_low_at", 32'(first_low), 32'd32);
    chk("accepted_48", 32'(accepted), 32'd48);
    chk("one_pulse", 32'(pulses), 32'd1);
    chk("both_full", 32'(InReady), 32'd0);
    Done = 1'b1;
    tick;
    Done = 1'b0;
    tick;
    chk("stream_fc", 32'(FrameCount), 32'd1);
    tick;
    chk("second_pulse", 32'(InputReady), 32'd1);

    // En dropped for 5 cycles at k=7.
    do_reset;
    send_frame;
    tick;
    chk("en_pulse", 32'(InputReady), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("en_word", 32'(Inputs), 32'(frame[i]));
    end
    En = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("en_hold", 32'(Inputs), 32'(frame[7]));
      chk("en_nopulse", 32'(InputReady), 32'd0);
      chk("en_inready", 32'(InReady), 32'd0);
    end
    En = 1'b1;
    for (int i = 8; i < 16; i++) begin
      tick;
      chk("en_resume", 32'(Inputs), 32'(frame[i]));
      chk("en_nopulse2", 32'(InputReady), 32'd0);
    end
    tick;
    chk("en_tail", 32'(Inputs), 32'd0);

    // Reset at k=10, then a fresh frame.
    do_reset;
    send_frame;
    tick;
    for (int i = 0; i < 11; i++) tick;
    chk("pre_rst_word", 32'(Inputs), 32'(frame[10]));
    Rst = 1'b1;
    tick;
    chk("abort_inputs", 32'(Inputs), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_inready", 32'(InReady), 32'd0);
    Rst = 1'b0;
    #1;
    send_frame;
    stream_check;

    // 256 frames wrap FrameCount.
    do_reset;
    for (int n = 0; n < 256; n++) begin
      frame[0] = 16'(n);
      send_frame;
      repeat (18) tick;
      Done = 1'b1;
      tick;
      Done = 1'b0;
      tick;
      chk("wrap_fc", 32'(FrameCount), 32'((n + 1) % 256));
    end
    chk("wrap_zero", 32'(FrameCount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
